// File: rtl/decode_pkg.sv
// Shared constants and control bundle for the decode pipeline stage.
package decode_pkg;

  localparam int unsigned DataWDefault    = 32;
  localparam int unsigned RegAddrWDefault = 5;
  localparam int unsigned ImmWDefault     = 16;

  // Decoded control bits carried alongside an instruction.
  typedef struct packed {
    logic branch;
    logic alu_src;
    logic reg_write;
    logic reg_dest;
    logic ext_zero;
  } ctrl_t;

endpackage

// File: rtl/reg_file_bypass.sv
// Register file with a hardwired zero register and two combinational read ports.
module reg_file_bypass #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0]     rdata_a_o,
  input  logic [REG_ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0]     rdata_b_o
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] mem_q [NumRegs];

  // Storage: cleared on reset, writes to register 0 are dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: register 0 always reads as zero.
  always_comb begin
    rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];
  end

endmodule

// File: rtl/decode_pipe_stage.sv
// Decode stage: operand read with forwarding, immediate handling, load-use
// hazard detection and the decode/execute pipeline register.
module decode_pipe_stage
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W     = DataWDefault,
  parameter int unsigned REG_ADDR_W = RegAddrWDefault,
  parameter int unsigned IMM_W      = ImmWDefault
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [IMM_W-1:0]      imm,
  input  logic                  branch,
  input  logic                  alu_src,
  input  logic                  reg_write,
  input  logic                  reg_dest,
  input  logic                  ext_zero,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  ex_reg_write,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic [DATA_W-1:0]     ex_data,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic [DATA_W-1:0]     to_alu1,
  output logic [DATA_W-1:0]     to_alu2,
  output logic [DATA_W-1:0]     stored_rt,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic                  out_reg_write,
  output logic                  out_is_load,
  output logic                  out_valid,
  output logic                  hazard_stall
);

  ctrl_t ctrl;
  assign ctrl = {branch, alu_src, reg_write, reg_dest, ext_zero};

  logic [DATA_W-1:0]     raw_rs, raw_rt;
  logic [REG_ADDR_W-1:0] src_addr [2];
  logic [DATA_W-1:0]     src_raw  [2];
  logic [DATA_W-1:0]     src_val  [2];
  logic [DATA_W-1:0]     ext_imm, const_val, op_b;
  logic [REG_ADDR_W-1:0] dest_sel;

  logic [DATA_W-1:0]     alu1_q, alu1_d, alu2_q, alu2_d, rt_q, rt_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic                  reg_write_q, reg_write_d;
  logic                  is_load_q, is_load_d;
  logic                  valid_q, valid_d;

  reg_file_bypass #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_reg_file (
    .clk_i     (clk),
    .rst_i     (reset),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (rs),
    .rdata_a_o (raw_rs),
    .raddr_b_i (rt),
    .rdata_b_o (raw_rt)
  );

  // Operand resolution: execute result beats writeback beats stored value.
  // A load in execute has no data yet, so it is never forwarded.
  always_comb begin
    src_addr[0] = rs;
    src_addr[1] = rt;
    src_raw[0]  = raw_rs;
    src_raw[1]  = raw_rt;
    for (int i = 0; i < 2; i++) begin
      src_val[i] = src_raw[i];
      if ((src_addr[i] != '0) && ex_reg_write && !ex_is_load && (ex_dest == src_addr[i])) begin
        src_val[i] = ex_data;
      end else if ((src_addr[i] != '0) && wb_en && (wb_addr == src_addr[i])) begin
        src_val[i] = wb_data;
      end
    end
  end

  // Immediate extension, operand B and destination selection.
  always_comb begin
    ext_imm   = ctrl.ext_zero ? {{(DATA_W - IMM_W){1'b0}}, imm}
                              : {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
    const_val = ctrl.branch ? '0 : ext_imm;
    op_b      = ctrl.alu_src ? const_val : src_val[1];
    dest_sel  = ctrl.reg_dest ? rd : rt;
  end

  // Load-use hazard: the needed value is still in flight from memory.
  always_comb begin
    hazard_stall = in_valid && ex_is_load && ex_reg_write && (ex_dest != '0) &&
                   ((ex_dest == rs) || (!ctrl.alu_src && (ex_dest == rt)));
  end

  // Pipeline register next state: flush, then hold, then hazard bubble, then load.
  always_comb begin
    alu1_d      = alu1_q;
    alu2_d      = alu2_q;
    rt_d        = rt_q;
    dest_d      = dest_q;
    reg_write_d = reg_write_q;
    is_load_d   = is_load_q;
    valid_d     = valid_q;
    if (flush || (!stall_in && hazard_stall)) begin
      alu1_d      = '0;
      alu2_d      = '0;
      rt_d        = '0;
      dest_d      = '0;
      reg_write_d = 1'b0;
      is_load_d   = 1'b0;
      valid_d     = 1'b0;
    end else if (!stall_in) begin
      alu1_d      = src_val[0];
      alu2_d      = op_b;
      rt_d        = src_val[1];
      dest_d      = dest_sel;
      reg_write_d = ctrl.reg_write && in_valid;
      // No memory-read control enters this stage, so nothing is marked as a load here.
      is_load_d   = 1'b0;
      valid_d     = in_valid;
    end
  end

  // Pipeline register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu1_q      <= '0;
      alu2_q      <= '0;
      rt_q        <= '0;
      dest_q      <= '0;
      reg_write_q <= 1'b0;
      is_load_q   <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      alu1_q      <= alu1_d;
      alu2_q      <= alu2_d;
      rt_q        <= rt_d;
      dest_q      <= dest_d;
      reg_write_q <= reg_write_d;
      is_load_q   <= is_load_d;
      valid_q     <= valid_d;
    end
  end

  assign to_alu1       = alu1_q;
  assign to_alu2       = alu2_q;
  assign stored_rt     = rt_q;
  assign out_dest      = dest_q;
  assign out_reg_write = reg_write_q;
  assign out_is_load   = is_load_q;
  assign out_valid     = valid_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Self-checking bench for decode_pipe_stage: directed scenarios plus random traffic
// compared against a behavioural model of the stage.
module tb_decode_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        branch, alu_src, reg_write, reg_dest, ext_zero;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_reg_write, ex_is_load;
  logic [4:0]  ex_dest;
  logic [31:0] ex_data;
  logic        stall_in, flush;
  logic [31:0] to_alu1, to_alu2, stored_rt;
  logic [4:0]  out_dest;
  logic        out_reg_write, out_is_load, out_valid, hazard_stall;

  decode_pipe_stage #(
    .DATA_W     (32),
    .REG_ADDR_W (5),
    .IMM_W      (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .imm           (imm),
    .branch        (branch),
    .alu_src       (alu_src),
    .reg_write     (reg_write),
    .reg_dest      (reg_dest),
    .ext_zero      (ext_zero),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .ex_reg_write  (ex_reg_write),
    .ex_is_load    (ex_is_load),
    .ex_dest       (ex_dest),
    .ex_data       (ex_data),
    .stall_in      (stall_in),
    .flush         (flush),
    .to_alu1       (to_alu1),
    .to_alu2       (to_alu2),
    .stored_rt     (stored_rt),
    .out_dest      (out_dest),
    .out_reg_write (out_reg_write),
    .out_is_load   (out_is_load),
    .out_valid     (out_valid),
    .hazard_stall  (hazard_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state: architectural registers and expected stage outputs.
  logic [31:0] m_rf [32];
  logic [31:0] m_alu1, m_alu2, m_srt;
  logic [4:0]  m_dest;
  logic        m_rw, m_ld, m_valid;

  logic [31:0] s_alu1, s_alu2, s_srt;
  logic [4:0]  s_dest;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_alu1 = 0; m_alu2 = 0; m_srt = 0; m_dest = 0;
    m_rw = 0; m_ld = 0; m_valid = 0;
  endtask

  // Value an instruction sees for register a this cycle.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (ex_reg_write && !ex_is_load && ex_dest == a) return ex_data;
    if (wb_en && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic logic model_hazard();
    return in_valid && ex_is_load && ex_reg_write && ex_dest != 0 &&
           (ex_dest == rs || (!alu_src && ex_dest == rt));
  endfunction

  function automatic logic [31:0] model_opb();
    logic [31:0] c;
    if (branch) c = 32'h0;
    else if (ext_zero) c = 32'(imm);
    else c = 32'(signed'(imm));
    return alu_src ? c : model_read(rt);
  endfunction

  task automatic check_outputs();
    check("to_alu1", to_alu1, m_alu1);
    check("to_alu2", to_alu2, m_alu2);
    check("stored_rt", stored_rt, m_srt);
    check("out_dest", 32'(out_dest), 32'(m_dest));
    check("out_reg_write", 32'(out_reg_write), 32'(m_rw));
    check("out_is_load", 32'(out_is_load), 32'(m_ld));
    check("out_valid", 32'(out_valid), 32'(m_valid));
  endtask

  task automatic clear_inputs();
    in_valid = 0; rs = 0; rt = 0; rd = 0; imm = 0;
    branch = 0; alu_src = 0; reg_write = 0; reg_dest = 0; ext_zero = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    ex_reg_write = 0; ex_is_load = 0; ex_dest = 0; ex_data = 0;
    stall_in = 0; flush = 0;
  endtask

  task automatic rand_inputs();
    in_valid = $urandom_range(0, 3) != 0;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    {branch, alu_src, reg_write, reg_dest, ext_zero} = 5'($urandom);
    wb_en = $urandom_range(0, 1); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
    ex_reg_write = $urandom_range(0, 1); ex_is_load = $urandom_range(0, 2) == 0;
    ex_dest = 5'($urandom_range(0, 7)); ex_data = $urandom;
    stall_in = $urandom_range(0, 5) == 0;
    flush = $urandom_range(0, 9) == 0;
  endtask

  // One clock: inputs already driven at the falling edge.
  task automatic step();
    logic        hz;
    logic [31:0] n_alu1, n_alu2, n_srt;
    logic [4:0]  n_dest;
    logic        n_rw, n_valid, bubble, hold;
    #1;
    hz = model_hazard();
    check("hazard_stall", 32'(hazard_stall), 32'(hz));
    bubble  = flush || (!stall_in && hz);
    hold    = !flush && stall_in;
    n_alu1  = model_read(rs);
    n_srt   = model_read(rt);
    n_alu2  = model_opb();
    n_dest  = reg_dest ? rd : rt;
    n_rw    = reg_write && in_valid;
    n_valid = in_valid;
    @(posedge clk);
    #1;
    if (bubble) begin
      m_alu1 = 0; m_alu2 = 0; m_srt = 0; m_dest = 0; m_rw = 0; m_ld = 0; m_valid = 0;
    end else if (!hold) begin
      m_alu1 = n_alu1; m_alu2 = n_alu2; m_srt = n_srt; m_dest = n_dest;
      m_rw = n_rw; m_ld = 0; m_valid = n_valid;
    end
    if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
    check_outputs();
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    reset = 0;

    // Writeback then read through the register file.
    clear_inputs(); wb_en = 1; wb_addr = 5; wb_data = 32'h1234;
    step();
    clear_inputs(); in_valid = 1; rs = 5;
    step();
    check("r5_read", to_alu1, 32'h1234);
    check("r5_valid", 32'(out_valid), 32'h1);

    // Execute result outranks same-cycle writeback.
    clear_inputs(); in_valid = 1; rs = 3;
    wb_en = 1; wb_addr = 3; wb_data = 32'hAA;
    ex_reg_write = 1; ex_dest = 3; ex_data = 32'hBB;
    step();
    check("ex_over_wb", to_alu1, 32'hBB);

    // Immediate extension and branch zeroing.
    clear_inputs(); in_valid = 1; imm = 16'h8000; alu_src = 1;
    step();
    check("imm_sext", to_alu2, 32'hFFFF8000);
    ext_zero = 1;
    step();
    check("imm_zext", to_alu2, 32'h00008000);
    branch = 1;
    step();
    check("imm_branch", to_alu2, 32'h0);

    // Load-use hazard and its suppression for register 0.
    clear_inputs(); in_valid = 1; rs = 7; reg_write = 1;
    ex_is_load = 1; ex_reg_write = 1; ex_dest = 7;
    #1 check("hz_load_use", 32'(hazard_stall), 32'h1);
    step();
    check("hz_bubble_valid", 32'(out_valid), 32'h0);
    check("hz_bubble_rw", 32'(out_reg_write), 32'h0);
    ex_dest = 0; rs = 0;
    #1 check("hz_dest0", 32'(hazard_stall), 32'h0);
    step();

    // Hold for three cycles, then flush wins over stall.
    clear_inputs(); in_valid = 1; rs = 5; rt = 3; rd = 9; reg_dest = 1; reg_write = 1;
    step();
    s_alu1 = to_alu1; s_alu2 = to_alu2; s_srt = stored_rt; s_dest = out_dest;
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); stall_in = 1; flush = 0; wb_en = 0;
      step();
      check("hold_alu1", to_alu1, s_alu1);
      check("hold_alu2", to_alu2, s_alu2);
      check("hold_rt", stored_rt, s_srt);
      check("hold_dest", 32'(out_dest), 32'(s_dest));
      check("hold_valid", 32'(out_valid), 32'h1);
    end
    stall_in = 1; flush = 1;
    step();
    check("flush_stall", 32'(out_valid), 32'h0);

    // Reset in the middle of a stall clears outputs and registers.
    clear_inputs(); wb_en = 1; wb_addr = 9; wb_data = 32'h55;
    step();
    clear_inputs(); in_valid = 1; rs = 9; reg_write = 1;
    step();
    check("r9_before_reset", to_alu1, 32'h55);
    stall_in = 1; in_valid = 0;
    @(posedge clk);
    #3 reset = 1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset = 0;
    clear_inputs(); in_valid = 1; rs = 9;
    step();
    check("r9_after_reset", to_alu1, 32'h0);
    check("valid_after_reset", 32'(out_valid), 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
